// File: rtl/inv_sqrt_pipe_pkg.sv
// -----------------------------------------------------------------------------
// inv_sqrt_pipe_pkg
// Shared constants and helpers for the inverse square-root engine:
//   TABSQR          - default constant-ROM base address of the tabsqr table
//   INV_SQRT_NONPOS - result returned for non-positive operands
//   state_e         - engine state encoding
//   sub_sat16       - 16-bit saturating subtract (ITU basic-op "sub")
// -----------------------------------------------------------------------------
package inv_sqrt_pipe_pkg;

  localparam int          TABSQR          = 256;
  localparam logic [31:0] INV_SQRT_NONPOS = 32'h3FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_ROM_A = 3'd2,
    ST_ROM_B = 3'd3,
    ST_MSU   = 3'd4,
    ST_SHR   = 3'd5,
    ST_OUT   = 3'd6
  } state_e;

  function automatic logic [15:0] sub_sat16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15]) sub_sat16 = d[16] ? 16'h8000 : 16'h7FFF;
    else                sub_sat16 = d[15:0];
  endfunction

endpackage

// File: rtl/norm_l32.sv
// -----------------------------------------------------------------------------
// norm_l32
// Combinational 32-bit leading-sign count (ITU basic-op norm_l): the number of
// left shifts that bring a signed value to bit 30 without changing its sign.
// Returns 0 for an input of 0, 31 for an input of -1.
// Ports:
//   x - signed 32-bit input
//   n - shift count, 0..31
// -----------------------------------------------------------------------------
module norm_l32 (
  input  logic [31:0] x,
  output logic [4:0]  n
);

  logic [30:0] s;

  always_comb begin
    s = x[31] ? ~x[30:0] : x[30:0];
    n = 5'd31;
    // ascending scan: the highest set bit of s is the last one to write n
    for (int i = 0; i < 31; i++) begin
      if (s[i]) n = 5'(30 - i);
    end
    if (x == 32'd0) n = 5'd0;
  end

endmodule

// File: rtl/inv_sqrt_pipe.sv
// -----------------------------------------------------------------------------
// inv_sqrt_pipe
// G.729 Inv_sqrt engine, bit-exact to the ITU basic-op reference:
// y = 1/sqrt(x) by normalisation, tabsqr lookup and linear interpolation.
// Operands arrive on a valid/ready stream with a caller tag; the result leaves
// on a valid/ready stream with the same tag. Only the tabsqr ROM is external.
//
// Parameters: IDX_W (table index bits), ROM_LAT (ROM read latency, 1..3),
//             ROM_AW (ROM address width), TAB_BASE (tabsqr base address),
//             TAG_W (caller tag width).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake; in_x (Q31), in_tag
//   out_valid/out_ready - result handshake; out_y, out_tag
//   rom_addr, rom_data  - constant ROM; data returns ROM_LAT cycles after addr
//   out_status[1:0]     - only when INV_SQRT_STATUS_EN is defined:
//                         bit0 non-positive input, bit1 MSU saturated
//
// State table:
//   state | meaning
//   IDLE  | in_ready high, wait for an operand
//   NORM  | normalise, derive exp/index/fraction, present tabsqr[i]
//   ROM_A | present tabsqr[i+1], capture t0 after ROM_LAT cycles
//   ROM_B | capture t1 after ROM_LAT cycles
//   MSU   | L_y = sat((t0<<16) - 2*sub_sat(t0,t1)*a)
//   SHR   | L_y >>>= exp, load output registers
//   OUT   | hold result until out_ready
// -----------------------------------------------------------------------------
module inv_sqrt_pipe
  import inv_sqrt_pipe_pkg::*;
#(
  parameter int IDX_W    = 6,
  parameter int ROM_LAT  = 1,
  parameter int ROM_AW   = 12,
  parameter int TAB_BASE = TABSQR,
  parameter int TAG_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_x,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_y,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data
`ifdef INV_SQRT_STATUS_EN
  ,
  output logic [1:0]        out_status
`endif
);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        x_q, x_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [14:0]        a_q, a_d;
  logic [4:0]         exp_q, exp_d;
  logic [15:0]        t0_q, t0_d, t1_q, t1_d;
  logic [31:0]        ly_q, ly_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_y_q, out_y_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [ROM_AW-1:0]  rom_addr_c;

  logic               accept_c, nonpos_c;
  logic [4:0]         n_c, e_c, exp_c;
  logic [31:0]        xs_c;
  logic [IDX_W-1:0]   idx_c;
  logic [14:0]        a_c;
  logic [15:0]        dt_c;
  logic signed [31:0] mul_c;
  logic [32:0]        diff_c;
  logic               msu_ovf_c;
  logic [31:0]        msu_c, shr_c;
  logic               unused_c;

  localparam logic [1:0] CNT_INIT = 2'(ROM_LAT - 1);

  assign accept_c = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign nonpos_c = in_x[31] || (in_x == 32'd0);

  norm_l32 u_norm (
    .x (x_q),
    .n (n_c)
  );

  // Normalise so bit 30 is set, then pre-shift right when the exponent is
  // even so the table always sees an odd exponent.
  assign e_c   = 5'd30 - n_c;
  assign exp_c = {1'b0, e_c[4:1]} + 5'd1;

  always_comb begin
    xs_c = x_q << n_c;
    if (!e_c[0]) xs_c = xs_c >> 1;
  end

  assign idx_c = xs_c[30 -: IDX_W] - IDX_W'(2 ** (IDX_W - 2));
  assign a_c   = xs_c[30-IDX_W -: 15];

  // tmp*a is at most 32768*32767 in magnitude, so doubling never overflows.
  assign dt_c      = sub_sat16(t0_q, t1_q);
  assign mul_c     = $signed({{16{dt_c[15]}}, dt_c}) * $signed({17'd0, a_q});
  assign diff_c    = {t0_q[15], t0_q, 16'd0} - {mul_c[30], mul_c[30:0], 1'b0};
  assign msu_ovf_c = diff_c[32] != diff_c[31];
  assign msu_c     = msu_ovf_c ? (diff_c[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                               : diff_c[31:0];
  assign shr_c     = 32'($signed(ly_q) >>> exp_q);

  assign unused_c = ^{xs_c[31], xs_c[15-IDX_W:0], mul_c[31]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    tag_d       = tag_q;
    i_d         = i_q;
    a_d         = a_q;
    exp_d       = exp_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    ly_d        = ly_q;
    in_ready_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_tag_d   = out_tag_q;
    rom_addr_c  = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (accept_c) begin
          in_ready_d = 1'b0;
          x_d        = in_x;
          tag_d      = in_tag;
          if (nonpos_c) begin
            out_y_d     = INV_SQRT_NONPOS;
            out_tag_d   = in_tag;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        i_d        = idx_c;
        a_d        = a_c;
        exp_d      = exp_c;
        rom_addr_c = ROM_AW'(TAB_BASE) + ROM_AW'(idx_c);
        cnt_d      = CNT_INIT;
        state_d    = ST_ROM_A;
      end
      ST_ROM_A: begin
        // held for all of ROM_A so t1 arrives across every ROM_B cycle
        rom_addr_c = ROM_AW'(TAB_BASE) + ROM_AW'(i_q) + ROM_AW'(1);
        if (cnt_q == 2'd0) begin
          t0_d    = rom_data;
          cnt_d   = CNT_INIT;
          state_d = ST_ROM_B;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_ROM_B: begin
        if (cnt_q == 2'd0) begin
          t1_d    = rom_data;
          state_d = ST_MSU;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_MSU: begin
        ly_d    = msu_c;
        state_d = ST_SHR;
      end
      ST_SHR: begin
        out_y_d     = shr_c;
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      tag_q       <= '0;
      i_q         <= '0;
      a_q         <= '0;
      exp_q       <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      ly_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      tag_q       <= tag_d;
      i_q         <= i_d;
      a_q         <= a_d;
      exp_q       <= exp_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      ly_q        <= ly_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;
  // gated so the address bus is quiet during the reset cycle itself
  assign rom_addr  = reset ? '0 : rom_addr_c;

`ifdef INV_SQRT_STATUS_EN
  logic [1:0] status_q, status_d;
  logic       sat_q, sat_d;

  always_comb begin
    status_d = status_q;
    sat_d    = sat_q;
    case (state_q)
      ST_IDLE: if (accept_c) begin
        status_d = {1'b0, nonpos_c};
        sat_d    = 1'b0;
      end
      ST_MSU:  sat_d    = msu_ovf_c;
      ST_SHR:  status_d = {sat_q, 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      sat_q    <= sat_d;
    end
  end

  assign out_status = status_q;
`endif

endmodule
